pixel_array_ctrl: RTL and testbench
===================================

# pixel_array_ctrl

Synchronous sequencer for the four-pixel array. It runs one full frame per start request: erase, expose, ramp conversion with an 8-bit Gray-free binary count driven onto the shared DATA bus, then sequential per-pixel readout. Captured pixel codes are presented one at a time with a valid strobe to the downstream digital logic. It is the only driver of the array's ERASE, EXPOSE, READ[3:0] and ramp-enable controls, and the only agent writing DATA during conversion.

## Interface
- C_ERASE, 5, erase phase length in cycles (≥1)
- C_EXPOSE, 255, expose phase length in cycles (≥1)
- C_CONVERT, 255, conversion phase length in cycles (1..256); counter value equals conversion cycle index
- C_READ, 5, read-select hold time per pixel in cycles (≥2)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  frame request, level-sampled in IDLE
- erase  output  1  array ERASE control
- expose  output  1  array EXPOSE control
- convert  output  1  ramp-generator enable; high for the whole conversion phase
- read  output  4  one-hot array READ select, bit i selects pixel i
- data_oe  output  1  high while the controller drives DATA (conversion only)
- data_cnt  output  8  counter value driven onto DATA when data_oe=1
- data_in  input  8  DATA bus as seen by the controller
- pix_data  output  8  captured code of last read pixel
- pix_idx  output  2  index of pix_data
- pix_valid  output  1  one-cycle strobe, pix_data/pix_idx valid
- busy  output  1  high in every state except IDLE
- frame_done  output  1  one-cycle strobe after pixel 3 captured

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ. All control outputs are registered Moore decodes of the current state: erase=ERASE, expose=EXPOSE, convert=data_oe=CONVERT, read=onehot(pix_sel) in READ, else 0.
- One phase counter (9 bits) cleared on every state entry; state advances when counter reaches C_x−1.
- IDLE: start=1 → ERASE next cycle. start=0 → stay.
- ERASE → EXPOSE → CONVERT, each after its parameter cycles; no gap cycles between phases.
- CONVERT: data_cnt = phase counter[7:0], starting 0 on first convert cycle, incrementing by 1 per cycle, no wrap (C_CONVERT ≤256 guarantees max 255). data_cnt returns to 0 on exit.
- READ: pix_sel starts 0. read[pix_sel] held C_READ cycles. On the last cycle of each hold, data_in is sampled into pix_data, pix_idx=pix_sel. pix_sel increments; after pix_sel=3 the state leaves READ.
- After READ: if start=1 in the last READ cycle → ERASE (back-to-back frame); else IDLE.
- start while busy: ignored, no queuing.
- reset: synchronous; from any state next state IDLE, phase counter and pix_sel cleared, all outputs 0 on the cycle after the reset edge, including mid-conversion (data_oe drops, bus released) and mid-readout (partial frame discarded, no pix_valid, no frame_done).

## Timing
- Reset values: every output 0.
- start sampled at edge T in IDLE → erase=1 from T+1.
- Frame length from first erase cycle to frame_done: C_ERASE+C_EXPOSE+C_CONVERT+4·C_READ+1 cycles.
- pix_valid asserted the cycle after the sampling edge; pix_data/pix_idx hold until next capture.
- frame_done coincides with pix_valid for pixel 3.
- read never has more than one bit set; read switches pixel with no idle gap; data_oe and any read bit never high in the same cycle (guaranteed by state exclusivity).
- busy=1 from first erase cycle through last READ cycle; busy drops together with return to IDLE.

## Test plan
- Reset, start=1 one cycle, defaults → erase 5 cycles, expose 255, convert 255 with data_cnt 0..254, read=0001,0010,0100,1000 each 5 cycles, frame_done at cycle 5+255+255+20+1 after start.
- Bus model returns 8'h12,8'h34,8'h56,8'h78 for pixels 0..3 → pix_valid four times with pix_idx 0..3 and those codes; frame_done with the 8'h78 strobe.
- C_CONVERT=256 → data_cnt reaches 255 on last convert cycle, no wrap to 0 while data_oe=1.
- start held high continuously → second erase begins the cycle after last READ cycle; mid-frame start pulses produce no extra frames.
- reset asserted during CONVERT at data_cnt=100 and again during READ of pixel 2 → all outputs 0 next cycle, no pix_valid/frame_done, IDLE until start.
- Assertion checks across all runs: read one-hot-or-zero, !(data_oe && |read), only one of erase/expose/convert high.

Source files
------------

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the four-pixel array: erase, expose, ramp convert, per-pixel readout.
// Outputs are registered decodes of the next state, so there is no combinational path; there is no backpressure and start is ignored while busy.
module pixel_array_ctrl #(
    parameter int C_ERASE   = 5,
    parameter int C_EXPOSE  = 255,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic [3:0] read,
    output logic       data_oe,
    output logic [7:0] data_cnt,
    input  logic [7:0] data_in,
    output logic [7:0] pix_data,
    output logic [1:0] pix_idx,
    output logic       pix_valid,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    localparam logic [8:0] ERASE_LAST   = 9'(C_ERASE - 1);
    localparam logic [8:0] EXPOSE_LAST  = 9'(C_EXPOSE - 1);
    localparam logic [8:0] CONVERT_LAST = 9'(C_CONVERT - 1);
    localparam logic [8:0] READ_LAST    = 9'(C_READ - 1);

    state_t     state;
    logic [8:0] cnt;
    logic [1:0] pix_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pix_sel    <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= '0;
            data_oe    <= 1'b0;
            data_cnt   <= '0;
            pix_data   <= '0;
            pix_idx    <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ERASE;
                        cnt   <= '0;
                        erase <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (cnt == ERASE_LAST) begin
                        state  <= S_EXPOSE;
                        cnt    <= '0;
                        erase  <= 1'b0;
                        expose <= 1'b1;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                S_EXPOSE: begin
                    if (cnt == EXPOSE_LAST) begin
                        state    <= S_CONVERT;
                        cnt      <= '0;
                        expose   <= 1'b0;
                        convert  <= 1'b1;
                        data_oe  <= 1'b1;
                        data_cnt <= '0;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                S_CONVERT: begin
                    // data_cnt tracks the phase counter so the ramp code equals the convert cycle index
                    if (cnt == CONVERT_LAST) begin
                        state    <= S_READ;
                        cnt      <= '0;
                        convert  <= 1'b0;
                        data_oe  <= 1'b0;
                        data_cnt <= '0;
                        pix_sel  <= '0;
                        read     <= 4'b0001;
                    end else begin
                        cnt      <= cnt + 9'd1;
                        data_cnt <= data_cnt + 8'd1;
                    end
                end
                S_READ: begin
                    if (cnt == READ_LAST) begin
                        cnt       <= '0;
                        pix_data  <= data_in;
                        pix_idx   <= pix_sel;
                        pix_valid <= 1'b1;
                        if (pix_sel == 2'd3) begin
                            frame_done <= 1'b1;
                            read       <= '0;
                            pix_sel    <= '0;
                            // start seen on the final read cycle chains straight into the next frame
                            if (start) begin
                                state <= S_ERASE;
                                erase <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            pix_sel <= pix_sel + 2'd1;
                            read    <= read << 1;
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    pix_sel <= '0;
                    erase   <= 1'b0;
                    expose  <= 1'b0;
                    convert <= 1'b0;
                    read    <= '0;
                    data_oe <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: default-parameter instance plus a C_CONVERT=256 instance.
module tb_pixel_array_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // instance A: default parameters
    logic       start_a = 1'b0;
    logic       erase_a, expose_a, convert_a, data_oe_a, pix_valid_a, busy_a, frame_done_a;
    logic [3:0] read_a;
    logic [7:0] data_cnt_a, data_in_a, pix_data_a;
    logic [1:0] pix_idx_a;

    // instance B: short phases, full 256-step ramp
    logic       start_b = 1'b0;
    logic       erase_b, expose_b, convert_b, data_oe_b, pix_valid_b, busy_b, frame_done_b;
    logic [3:0] read_b;
    logic [7:0] data_cnt_b, data_in_b, pix_data_b;
    logic [1:0] pix_idx_b;

    function automatic logic [7:0] bus(input logic oe, input logic [7:0] cnt, input logic [3:0] rd);
        if (oe)         return cnt;
        else if (rd[0]) return 8'h12;
        else if (rd[1]) return 8'h34;
        else if (rd[2]) return 8'h56;
        else if (rd[3]) return 8'h78;
        else            return 8'h00;
    endfunction

    assign data_in_a = bus(data_oe_a, data_cnt_a, read_a);
    assign data_in_b = bus(data_oe_b, data_cnt_b, read_b);

    pixel_array_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .erase(erase_a), .expose(expose_a), .convert(convert_a), .read(read_a),
        .data_oe(data_oe_a), .data_cnt(data_cnt_a), .data_in(data_in_a),
        .pix_data(pix_data_a), .pix_idx(pix_idx_a), .pix_valid(pix_valid_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    pixel_array_ctrl #(.C_ERASE(2), .C_EXPOSE(3), .C_CONVERT(256), .C_READ(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .erase(erase_b), .expose(expose_b), .convert(convert_b), .read(read_b),
        .data_oe(data_oe_b), .data_cnt(data_cnt_b), .data_in(data_in_b),
        .pix_data(pix_data_b), .pix_idx(pix_idx_b), .pix_valid(pix_valid_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic invariants();
        check("onehot_a", 32'($onehot0(read_a)), 32'd1);
        check("oe_read_a", 32'(data_oe_a && (|read_a)), 32'd0);
        check("phase_excl_a", 32'($countones({erase_a, expose_a, convert_a}) <= 1), 32'd1);
        check("onehot_b", 32'($onehot0(read_b)), 32'd1);
        check("oe_read_b", 32'(data_oe_b && (|read_b)), 32'd0);
        check("phase_excl_b", 32'($countones({erase_b, expose_b, convert_b}) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        invariants();
    endtask

    function automatic logic [31:0] all_out_a();
        return 32'({erase_a, expose_a, convert_a, data_oe_a, read_a, busy_a, pix_valid_a,
                    frame_done_a, data_cnt_a, pix_data_a, pix_idx_a});
    endfunction

    function automatic logic [31:0] all_out_b();
        return 32'({erase_b, expose_b, convert_b, data_oe_b, read_b, busy_b, pix_valid_b,
                    frame_done_b, data_cnt_b, pix_data_b, pix_idx_b});
    endfunction

    // Walks one frame of instance A from its first erase cycle (k=1) to the frame_done cycle.
    // mode 0: start low; mode 1: start held high (next frame chains); mode 2: stray start pulses.
    // overlap: cycle 1 coincides with the previous frame's final strobe.
    task automatic walk_a(input int mode, input bit overlap);
        int e, x, c, r, len, ph;
        logic er, ex, cv, bsy, pv, fd;
        logic [3:0] rd;
        logic [7:0] cnt, codes [4];
        codes = '{8'h12, 8'h34, 8'h56, 8'h78};
        e = 5; x = 255; c = 255; r = 5;
        len = e + x + c + 4 * r + 1;
        for (int k = 1; k <= len; k++) begin
            er = 0; ex = 0; cv = 0; rd = 4'b0; cnt = 8'd0;
            ph = k - e - x - c - 1;
            if (k <= e)                 er = 1;
            else if (k <= e + x)        ex = 1;
            else if (k <= e + x + c)    begin cv = 1; cnt = 8'(k - e - x - 1); end
            else if (k < len)           rd = 4'b0001 << (ph / r);
            bsy = (k < len) || (mode == 1);
            if (k == len && mode == 1) er = 1;
            pv = (ph > 0) && (ph % r == 0);
            fd = (k == len);
            if (k == 1 && overlap) begin pv = 1; fd = 1; end
            check($sformatf("frame_a k=%0d", k),
                  32'({erase_a, expose_a, convert_a, data_oe_a, read_a, busy_a, pix_valid_a, frame_done_a, data_cnt_a}),
                  32'({er, ex, cv, cv, rd, bsy, pv, fd, cnt}));
            if (pv && ph > 0) begin
                check($sformatf("pix_a k=%0d", k), 32'({pix_idx_a, pix_data_a}),
                      32'({2'(ph / r - 1), codes[ph / r - 1]}));
            end
            if (mode == 1)      start_a = 1'b1;
            else if (mode == 2) start_a = (k % 7 == 0) && (k < len - 1);
            else                start_a = 1'b0;
            if (k < len) tick();
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("reset_a", all_out_a(), 32'd0);
        check("reset_b", all_out_b(), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_a", all_out_a(), 32'd0);

        // single frame from a one-cycle start pulse
        start_a = 1'b1;
        tick();
        walk_a(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_idle_a", 32'({busy_a, erase_a, pix_valid_a, frame_done_a}), 32'd0);
            check("pix_hold_a", 32'({pix_idx_a, pix_data_a}), 32'({2'd3, 8'h78}));
        end

        // back-to-back frames, then a frame with ignored stray start pulses
        start_a = 1'b1;
        tick();
        walk_a(1, 1'b0);
        walk_a(2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_idle2_a", 32'({busy_a, erase_a, pix_valid_a, frame_done_a}), 32'd0);
        end

        // reset during conversion at data_cnt = 100
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (360) tick();
        check("mid_conv_cnt_a", 32'({data_oe_a, data_cnt_a}), 32'({1'b1, 8'd100}));
        reset = 1'b1;
        tick();
        check("rst_conv_a", all_out_a(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("after_rst_conv_a", all_out_a(), 32'd0);
        end

        // reset during readout of pixel 2
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (526) tick();
        check("mid_read_a", 32'({read_a, pix_idx_a, pix_data_a}), 32'({4'b0100, 2'd1, 8'h34}));
        reset = 1'b1;
        tick();
        check("rst_read_a", all_out_a(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("after_rst_read_a", all_out_a(), 32'd0);
        end

        // 256-cycle conversion: ramp reaches 255 without wrapping
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 1; k <= 270; k++) begin
            logic cv;
            cv = (k > 5) && (k <= 261);
            check($sformatf("ramp_b k=%0d", k), 32'({convert_b, data_oe_b, data_cnt_b, frame_done_b}),
                  32'({cv, cv, cv ? 8'(k - 6) : 8'd0, k == 270}));
            if (k == 261) check("ramp_max_b", 32'(data_cnt_b), 32'd255);
            if (k < 270) tick();
        end
        check("final_pix_b", 32'({pix_valid_b, pix_idx_b, pix_data_b}), 32'({1'b1, 2'd3, 8'h78}));
        tick();
        check("idle_b", 32'({busy_b, pix_valid_b, frame_done_b}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
